ahb_cmd_manager: RTL and testbench
==================================

Name: ahb_cmd_manager

Overview:
- Single-transfer AHB manager that converts a valid/ready command stream into pipelined AHB address and data phases.
- Drives an AHB subordinate such as SubDummy through AHBCommon_if-compatible signals.
- Returns read data and error status through a 2-entry response FIFO with backpressure.
- Upstream stimulus stage for subordinate benches and the first piece of a real interconnect.

Parameters:
- AddrWidth, 32, width of command and bus address.
- DataWidth, 32, width of read and write data.
- TimeoutCycles, 256, wait-state limit; used only with AHB_MGR_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nReset  in  1  synchronous active-low reset.
- cmdValid  in  1  command offered.
- cmdReady  out  1  command accepted when cmdValid && cmdReady.
- cmdAddr  in  AddrWidth  transfer address.
- cmdWrite  in  1  1 = write, 0 = read.
- cmdWData  in  DataWidth  write data.
- cmdControl  in  4  passed to the bus control field.
- rspValid  out  1  response available (FIFO head).
- rspReady  in  1  response consumed.
- rspData  out  DataWidth  read data; 0 for writes.
- rspErr  out  1  transfer ended with non-OKAY resp, or timed out.
- addr  out  AddrWidth  bus address.
- control  out  4  bus control.
- trans  out  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- write  out  1  bus write.
- wData  out  DataWidth  bus write data.
- rData  in  DataWidth  bus read data.
- resp  in  2  OKAY=00; any other value is an error.
- ready  in  1  subordinate readyOut.

Behaviour:
Reset:
- nReset low at a clk edge clears the address-phase register, data-phase register, credit counter, response FIFO and error state.
- Reset values: trans=IDLE, addr=0, control=0, write=0, wData=0, rspValid=0, rspData=0, rspErr=0, cmdReady=0.
- Reset mid-transfer discards all in-flight commands; no responses are produced for them.

Pipeline:
- Address-phase register A: valid, addr, write, control, wdata.
- Data-phase register D: valid, write, wdata.
- trans=NONSEQ when A.valid and not cancelling; otherwise IDLE.
- addr, control and write come from A; they are 0 when A is empty.
- wData = D.wdata when D.valid && D.write; otherwise 0.
- Bus outputs are driven only from registers; no combinational path from cmd* to the bus.
- On a clk edge with ready=1, A moves to D, and the accepted command (if any) loads A.
- With ready=0, A and D hold and the address stays stable.
- Command latency: a command accepted at edge N drives NONSEQ in cycle N+1. With zero wait states, its response is pushed at edge N+2 and rspValid is high in cycle N+2.
- Back-to-back commands sustain one transfer per cycle when ready=1 and rspReady=1.

Credits:
- credit = accepted commands not yet popped from the response FIFO, range 0..2.
- cmdReady = nReset && (credit<2 || pop this cycle) && (!A.valid || ready) && !errCancel.
- The FIFO cannot overflow. Simultaneous accept and pop leaves credit unchanged.

Response:
- When D.valid && ready=1, push {rData (or 0 for writes), resp!=OKAY} into the FIFO.
- Pop occurs when rspValid && rspReady. FIFO order equals command order.

Error (two-cycle AHB response):
- Cycle 1 is D.valid, resp!=OKAY, ready=0.
- In cycle 1, assert errCancel: trans is forced to IDLE for the pending A and cmdReady=0. A is retained, not moved to D.
- Cycle 2 (ready=1) pushes the error response and clears errCancel.
- The retained A reissues as NONSEQ on the next cycle. Cancelled commands are never lost or duplicated.

Optional Feature:
- Macro AHB_MGR_TIMEOUT_EN.
- Defined:
  - A wait counter increments while D.valid && ready=0, and clears on ready=1.
  - When the counter reaches TimeoutCycles, D is retired with rspErr=1 and rspData=0.
  - A is cancelled as in the error case and reissued.
  - The counter resets to 0.
- Undefined: no counter logic; the manager waits indefinitely.

Test Plan:
- Reset then single write cmdAddr=0x10, cmdWData=0xDEADBEEF, ready=1 -> cycle N+1: trans=10, addr=0x10, write=1. Cycle N+2: wData=0xDEADBEEF, rspValid=1, rspErr=0.
- Read cmdAddr=0x20 with subordinate rData=0x12345678 and 3 wait states -> addr held stable 4 cycles; rspData=0x12345678, rspErr=0.
- Four back-to-back reads, ready=1, rspReady=1 -> NONSEQ every cycle, responses in order, credit never exceeds 2.
- rspReady=0 with three commands offered -> only 2 accepted, cmdReady=0 until a pop, no FIFO overflow.
- Command X in the data phase gets resp=01 for 2 cycles while command Y is in the address phase -> trans=IDLE in error cycle 1, X response has rspErr=1, Y reissued as NONSEQ and completes OKAY.
- With AHB_MGR_TIMEOUT_EN and TimeoutCycles=4, ready held 0 -> response with rspErr=1 after 4 wait cycles. Without the macro, no response.
- nReset low mid-burst with credit=2 -> next cycle trans=IDLE, rspValid=0, cmdReady=0; after release, a new command completes normally.

Source files
------------

// File: rtl/ahb_cmd_manager.sv
// ahb_cmd_manager: single-transfer AHB manager. A valid/ready command stream
// feeds a two-stage address/data pipeline, and responses return through a
// 2-entry fall-through FIFO. Credits bound the number of commands in flight,
// so the FIFO cannot overflow.
//
// Optional feature: define AHB_MGR_TIMEOUT_EN to retire a data phase with an
// error after TimeoutCycles wait states. Without it the manager waits
// indefinitely.
//
// Error-cancel FSM:
//   state    | meaning
//   ERR_NONE | normal operation; cancel only in the first cycle of an error
//   ERR_HOLD | second error cycle pending; A stays cancelled until ready=1
module ahb_cmd_manager #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  input  logic [AddrWidth-1:0] cmdAddr,
  input  logic                 cmdWrite,
  input  logic [DataWidth-1:0] cmdWData,
  input  logic [3:0]           cmdControl,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [DataWidth-1:0] rspData,
  output logic                 rspErr,
  output logic [AddrWidth-1:0] addr,
  output logic [3:0]           control,
  output logic [1:0]           trans,
  output logic                 write,
  output logic [DataWidth-1:0] wData,
  input  logic [DataWidth-1:0] rData,
  input  logic [1:0]           resp,
  input  logic                 ready
);

  typedef enum logic [0:0] {ERR_NONE, ERR_HOLD} err_state_t;

  // address-phase register
  logic                 a_valid;
  logic                 a_write;
  logic [AddrWidth-1:0] a_addr;
  logic [3:0]           a_control;
  logic [DataWidth-1:0] a_wdata;
  // data-phase register
  logic                 d_valid;
  logic                 d_write;
  logic [DataWidth-1:0] d_wdata;

  logic [1:0]           credit;
  logic [DataWidth-1:0] fifo_data [0:1];
  logic [1:0]           fifo_err;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           fifo_count;

  err_state_t           err_state;
  err_state_t           err_state_next;

  logic                 err_first;
  logic                 err_cancel;
  logic                 timeout_now;
  logic                 retire;
  logic                 advance;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 store;
  logic                 pop_mem;
  logic                 fifo_empty;
  logic [DataWidth-1:0] push_data;
  logic                 push_err;

`ifdef AHB_MGR_TIMEOUT_EN
  localparam int WaitW = $clog2(TimeoutCycles + 1);
  logic [WaitW-1:0] wait_cnt;

  // Count wait states of the current data phase; restart on ready or retire.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      wait_cnt <= '0;
    end else if (!d_valid || ready || timeout_now) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_now = d_valid && !ready && (wait_cnt == WaitW'(TimeoutCycles));
`else
  assign timeout_now = 1'b0;
`endif

  // First cycle of a two-cycle error response; the pending address phase is
  // withdrawn here and stays withdrawn through the second cycle.
  assign err_first  = d_valid && (resp != 2'b00) && !ready;
  assign err_cancel = err_first || (err_state == ERR_HOLD) || timeout_now;

  assign retire  = d_valid && (ready || timeout_now);
  assign advance = ready && !err_cancel;
  assign push    = nReset && retire;

  assign push_data = (timeout_now || d_write) ? '0 : rData;
  assign push_err  = timeout_now || (resp != 2'b00);

  // Fall-through FIFO: a response pushed this cycle is visible immediately,
  // which lets one credit turn around every cycle at full throughput.
  assign fifo_empty = (fifo_count == 2'd0);
  assign rspValid   = !fifo_empty || push;
  assign rspData    = !fifo_empty ? fifo_data[rd_ptr] : (push ? push_data : '0);
  assign rspErr     = !fifo_empty ? fifo_err[rd_ptr]  : (push && push_err);
  assign pop        = rspValid && rspReady;
  assign store      = push && !(pop && fifo_empty);
  assign pop_mem    = pop && !fifo_empty;

  assign cmdReady = nReset && ((credit < 2'd2) || pop) && (!a_valid || ready) && !err_cancel;
  assign accept   = cmdValid && cmdReady;

  // Bus outputs come only from the pipeline registers.
  assign trans   = (a_valid && !err_cancel) ? 2'b10 : 2'b00;
  assign addr    = a_valid ? a_addr : '0;
  assign control = a_valid ? a_control : 4'h0;
  assign write   = a_valid && a_write;
  assign wData   = (d_valid && d_write) ? d_wdata : '0;

  // Error-cancel state register.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      err_state <= ERR_NONE;
    end else begin
      err_state <= err_state_next;
    end
  end

  // Error-cancel next state: hold until the subordinate completes the response.
  always_comb begin
    err_state_next = err_state;
    unique case (err_state)
      ERR_NONE: if (err_first && !timeout_now) err_state_next = ERR_HOLD;
      ERR_HOLD: if (ready || timeout_now) err_state_next = ERR_NONE;
      default:  err_state_next = ERR_NONE;
    endcase
  end

  // Address and data phase registers.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      a_valid   <= 1'b0;
      a_write   <= 1'b0;
      a_addr    <= '0;
      a_control <= 4'h0;
      a_wdata   <= '0;
      d_valid   <= 1'b0;
      d_write   <= 1'b0;
      d_wdata   <= '0;
    end else begin
      if (advance) begin
        d_valid <= a_valid;
        d_write <= a_write;
        d_wdata <= a_wdata;
      end else if (retire) begin
        d_valid <= 1'b0;
      end
      if (accept) begin
        a_valid   <= 1'b1;
        a_write   <= cmdWrite;
        a_addr    <= cmdAddr;
        a_control <= cmdControl;
        a_wdata   <= cmdWData;
      end else if (advance) begin
        a_valid <= 1'b0;
      end
    end
  end

  // Credits: commands accepted but not yet popped from the response FIFO.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      credit <= 2'd0;
    end else if (accept && !pop) begin
      credit <= credit + 2'd1;
    end else if (!accept && pop) begin
      credit <= credit - 2'd1;
    end
  end

  // Response FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_err     <= 2'b00;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_count   <= 2'd0;
    end else begin
      if (store) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_err[wr_ptr]  <= push_err;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop_mem) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= fifo_count + 2'(store) - 2'(pop_mem);
    end
  end

endmodule

// File: tb/tb_ahb_cmd_manager.sv
// Directed bench for ahb_cmd_manager with a response scoreboard.
module tb_ahb_cmd_manager;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [31:0] cmdAddr = '0;
  logic        cmdWrite = 1'b0;
  logic [31:0] cmdWData = '0;
  logic [3:0]  cmdControl = '0;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [31:0] rspData;
  logic        rspErr;
  logic [31:0] addr;
  logic [3:0]  control;
  logic [1:0]  trans;
  logic        write;
  logic [31:0] wData;
  logic [31:0] rData;
  logic [1:0]  resp = 2'b00;
  logic        ready = 1'b0;

  int   vectors = 0;
  int   miscompares = 0;
  rsp_t exp_q[$];
  rsp_t pend;

  logic        sub_valid;
  logic [31:0] sub_addr;

  always #5 clk = ~clk;

  ahb_cmd_manager #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(4)) dut (
    .clk(clk), .nReset(nReset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdAddr(cmdAddr),
    .cmdWrite(cmdWrite), .cmdWData(cmdWData), .cmdControl(cmdControl),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspErr(rspErr),
    .addr(addr), .control(control), .trans(trans), .write(write),
    .wData(wData), .rData(rData), .resp(resp), .ready(ready)
  );

  // Subordinate read-data model: data phase returns addr ^ 0x12345658.
  always @(posedge clk) begin
    if (!nReset) begin
      sub_valid <= 1'b0;
      sub_addr  <= '0;
    end else if (ready) begin
      sub_valid <= (trans == 2'b10) && !write;
      sub_addr  <= addr;
    end
  end
  assign rData = sub_valid ? (sub_addr ^ 32'h1234_5658) : 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed response is compared against the scoreboard head.
  always @(negedge clk) begin
    if (nReset && rspValid && rspReady) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got data %0h err %0b expected none", rspData, rspErr);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", {32'h0, rspData}, {32'h0, e.data});
        chk("rsp_err", {63'h0, rspErr}, {63'h0, e.err});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample point; records the expected response of an accepted command.
  task automatic neg();
    @(negedge clk);
    if (nReset && cmdValid && cmdReady) exp_q.push_back(pend);
  endtask

  task automatic offer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee);
    cmdValid   = 1'b1;
    cmdAddr    = a;
    cmdWrite   = w;
    cmdWData   = wd;
    cmdControl = 4'h3;
    pend       = '{data: ed, err: ee};
  endtask

  task automatic idle_cmd();
    cmdValid = 1'b0;
  endtask

  initial begin
    logic exp_rv;
    // ---- reset state ----
    step();
    neg();
    chk("rst_trans", {62'h0, trans}, 64'h0);
    chk("rst_addr", {32'h0, addr}, 64'h0);
    chk("rst_ctrl_wr", {59'h0, control, write}, 64'h0);
    chk("rst_wdata", {32'h0, wData}, 64'h0);
    chk("rst_rsp", {31'h0, rspData, rspValid, rspErr}, 64'h0);
    chk("rst_cmdready", {63'h0, cmdReady}, 64'h0);
    step();

    // ---- single write ----
    nReset = 1'b1; ready = 1'b1; rspReady = 1'b1;
    offer(32'h10, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
    neg();
    chk("t1_cmdready", {63'h0, cmdReady}, 64'h1);
    step();
    idle_cmd();
    neg();
    chk("t1_trans", {62'h0, trans}, 64'h2);
    chk("t1_addr", {32'h0, addr}, 64'h10);
    chk("t1_write_ctrl", {59'h0, control, write}, {59'h0, 4'h3, 1'b1});
    step();
    neg();
    chk("t1_wdata", {32'h0, wData}, 64'hDEAD_BEEF);
    chk("t1_rspvalid", {63'h0, rspValid}, 64'h1);
    step();
    neg();
    chk("t1_idle", {61'h0, trans, rspValid}, 64'h0);
    step();

    // ---- write then read with 3 wait states on the write ----
    offer(32'h1C, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0);
    neg(); step();
    offer(32'h20, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
    neg();
    chk("t2_cmdready", {63'h0, cmdReady}, 64'h1);
    step();
    idle_cmd();
    for (int i = 0; i < 4; i++) begin
      ready = (i == 3);
      neg();
      chk("t2_addr_stable", {32'h0, addr}, 64'h20);
      chk("t2_trans_stable", {62'h0, trans}, 64'h2);
      if (i == 0) chk("t2_wdata", {32'h0, wData}, 64'hA5A5_A5A5);
      step();
    end
    neg();
    chk("t2_rspvalid", {63'h0, rspValid}, 64'h1);
    step();

    // ---- four back-to-back reads ----
    for (int i = 0; i < 6; i++) begin
      if (i < 4) offer(32'h40 + 32'(4 * i), 1'b0, 32'h0,
                       32'h1234_5658 ^ (32'h40 + 32'(4 * i)), 1'b0);
      else idle_cmd();
      neg();
      if (i < 4) chk("t3_cmdready", {63'h0, cmdReady}, 64'h1);
      if (i >= 1 && i <= 4) begin
        chk("t3_trans", {62'h0, trans}, 64'h2);
        chk("t3_addr", {32'h0, addr}, {32'h0, 32'h40 + 32'(4 * (i - 1))});
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin neg(); step(); end

    // ---- backpressure: rspReady=0, three commands ----
    rspReady = 1'b0;
    offer(32'h60, 1'b0, 32'h0, 32'h1234_5638, 1'b0);
    neg(); chk("t4_acc1", {63'h0, cmdReady}, 64'h1); step();
    offer(32'h64, 1'b0, 32'h0, 32'h1234_563C, 1'b0);
    neg(); chk("t4_acc2", {63'h0, cmdReady}, 64'h1); step();
    offer(32'h68, 1'b0, 32'h0, 32'h1234_5630, 1'b0);
    neg(); chk("t4_block1", {63'h0, cmdReady}, 64'h0); step();
    neg();
    chk("t4_block2", {63'h0, cmdReady}, 64'h0);
    chk("t4_head", {31'h0, rspData, rspValid}, {31'h0, 32'h1234_5638, 1'b1});
    step();
    neg();
    chk("t4_block3", {63'h0, cmdReady}, 64'h0);
    chk("t4_no_issue", {62'h0, trans}, 64'h0);
    step();
    rspReady = 1'b1;
    neg(); chk("t4_after_pop", {63'h0, cmdReady}, 64'h1); step();
    idle_cmd();
    for (int i = 0; i < 4; i++) begin neg(); step(); end

    // ---- two-cycle error on X while Y waits in the address phase ----
    offer(32'h80, 1'b1, 32'h1111_1111, 32'h0, 1'b1);
    neg(); step();
    offer(32'h84, 1'b0, 32'h0, 32'h1234_56DC, 1'b0);
    neg(); step();
    idle_cmd();
    ready = 1'b0; resp = 2'b01;
    neg();
    chk("t5_err1_trans", {62'h0, trans}, 64'h0);
    chk("t5_err1_cmdready", {63'h0, cmdReady}, 64'h0);
    step();
    ready = 1'b1;
    neg();
    chk("t5_err2_rspvalid", {63'h0, rspValid}, 64'h1);
    step();
    resp = 2'b00;
    neg();
    chk("t5_reissue", {30'h0, trans, addr}, {30'h0, 2'b10, 32'h84});
    step();
    neg();
    chk("t5_y_done", {61'h0, trans, rspValid}, {61'h0, 2'b00, 1'b1});
    step();

    // ---- wait-state timeout ----
    offer(32'hA0, 1'b0, 32'h0,
`ifdef AHB_MGR_TIMEOUT_EN
          32'h0, 1'b1);
`else
          32'h1234_56F8, 1'b0);
`endif
    neg(); step();
    idle_cmd();
    neg(); step();
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
`ifdef AHB_MGR_TIMEOUT_EN
      exp_rv = (i == 4);
`else
      exp_rv = 1'b0;
`endif
      neg();
      chk("t6_rspvalid", {63'h0, rspValid}, {63'h0, exp_rv});
      step();
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin neg(); step(); end

    // ---- reset mid-burst with two credits outstanding ----
    rspReady = 1'b0;
    offer(32'hC0, 1'b0, 32'h0, 32'h1234_5698, 1'b0);
    neg(); step();
    offer(32'hC4, 1'b0, 32'h0, 32'h1234_569C, 1'b0);
    neg(); step();
    idle_cmd();
    neg(); step();
    nReset = 1'b0;
    exp_q.delete();
    neg();
    chk("t7_rst_cmdready", {63'h0, cmdReady}, 64'h0);
    step();
    neg();
    chk("t7_rst_state", {60'h0, trans, rspValid, cmdReady}, 64'h0);
    step();
    nReset = 1'b1; rspReady = 1'b1;
    offer(32'hE0, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b0);
    neg(); chk("t7_new_cmd", {63'h0, cmdReady}, 64'h1); step();
    idle_cmd();
    neg(); chk("t7_new_trans", {30'h0, trans, addr}, {30'h0, 2'b10, 32'hE0}); step();

    // ---- drain scoreboard with a bounded wait ----
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin neg(); step(); end
    chk("drain_pending", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
